// File: rtl/coll_pair_scheduler_if.sv
// Operand/result bus between the pair scheduler (master) and the collision detector (slave).
//
// Handshake: the master raises cd_in_rdy with all operands stable and keeps both
// unchanged until it samples cd_out_rdy=1 on a rising clock edge; that edge
// transfers cd_hit. cd_in_rdy then drops for at least one cycle before the next
// request. cd_hit is meaningful only while cd_out_rdy=1.
interface coll_pair_scheduler_if;
    logic [15:0] cd_xa;
    logic [15:0] cd_ya;
    logic [15:0] cd_vxa;
    logic [15:0] cd_vya;
    logic [15:0] cd_xb;
    logic [15:0] cd_yb;
    logic [15:0] cd_vxb;
    logic [15:0] cd_vyb;
    logic [31:0] cd_r;
    logic        cd_in_rdy;
    logic        cd_out_rdy;
    logic        cd_hit;

    modport master (
        output cd_xa, cd_ya, cd_vxa, cd_vya,
        output cd_xb, cd_yb, cd_vxb, cd_vyb,
        output cd_r, cd_in_rdy,
        input  cd_out_rdy, cd_hit
    );

    modport slave (
        input  cd_xa, cd_ya, cd_vxa, cd_vya,
        input  cd_xb, cd_yb, cd_vxb, cd_vyb,
        input  cd_r, cd_in_rdy,
        output cd_out_rdy, cd_hit
    );
endinterface

// File: rtl/coll_pair_scheduler.sv
// Walks every bot pair (i<j) through the collision detector and builds a hit mask/count.
// Optional macro COLL_TIMEOUT_EN adds a detector response timeout that aborts the sweep with err.
module coll_pair_scheduler #(
    parameter int NUM_BOTS = 4,
    parameter int IDX_W    = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [15:0]           load_x,
    input  logic [15:0]           load_y,
    input  logic [15:0]           load_vx,
    input  logic [15:0]           load_vy,
    input  logic [31:0]           radius,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    coll_pair_scheduler_if.master cd,
    output logic [NUM_BOTS-1:0]   hit_mask,
    output logic [7:0]            hit_count,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Snapshot depth covers the whole index space so i/j/load_idx index it
    // without width games; entries >= NUM_BOTS are never written and stay 0.
    localparam int DEPTH = 1 << IDX_W;

    if (NUM_BOTS < 2 || NUM_BOTS > 16 || DEPTH < NUM_BOTS || TIMEOUT < 1) begin : g_bad_cfg
        $error("coll_pair_scheduler: illegal NUM_BOTS/IDX_W/TIMEOUT combination");
    end

    state_t               state;
    state_t               state_nx;
    logic [IDX_W-1:0]     i_idx;
    logic [IDX_W-1:0]     j_idx;
    logic [15:0]          snap_x  [DEPTH];
    logic [15:0]          snap_y  [DEPTH];
    logic [15:0]          snap_vx [DEPTH];
    logic [15:0]          snap_vy [DEPTH];
    logic                 load_ok;
    logic                 last_pair;
    logic                 timed_out;
    logic [NUM_BOTS-1:0]  pair_bits;

    assign state_dbg = state;
    assign load_ok   = (state == IDLE) && load_en && (32'(load_idx) < NUM_BOTS);
    assign last_pair = (i_idx == IDX_W'(NUM_BOTS - 2)) && (j_idx == IDX_W'(NUM_BOTS - 1));

    always_comb begin
        pair_bits = '0;
        for (int k = 0; k < NUM_BOTS; k++) begin
            pair_bits[k] = (IDX_W'(k) == i_idx) || (IDX_W'(k) == j_idx);
        end
    end

`ifdef COLL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // The first WAIT cycle only presents the request, so the detector gets
    // TIMEOUT full cycles after that before the sweep is abandoned.
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT + 1));
    assign err       = err_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else if (!timed_out) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            err_q <= 1'b0;
        end else if (state == WAIT && !cd.cd_out_rdy && timed_out) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        done         = 1'b0;
        cd.cd_in_rdy = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                busy     = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                busy         = 1'b1;
                cd.cd_in_rdy = 1'b1;
                if (cd.cd_out_rdy) begin
                    state_nx = NEXT;
                end else if (timed_out) begin
                    state_nx = FIN;
                end
            end
            NEXT: begin
                busy     = 1'b1;
                state_nx = last_pair ? FIN : ISSUE;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                snap_x[k]  <= '0;
                snap_y[k]  <= '0;
                snap_vx[k] <= '0;
                snap_vy[k] <= '0;
            end
        end else if (load_ok) begin
            snap_x[load_idx]  <= load_x;
            snap_y[load_idx]  <= load_y;
            snap_vx[load_idx] <= load_vx;
            snap_vy[load_idx] <= load_vy;
        end
    end

    // Operands are captured at the end of ISSUE and held through WAIT.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            i_idx     <= '0;
            j_idx     <= IDX_W'(1);
            hit_mask  <= '0;
            hit_count <= '0;
            cd.cd_xa  <= '0;
            cd.cd_ya  <= '0;
            cd.cd_vxa <= '0;
            cd.cd_vya <= '0;
            cd.cd_xb  <= '0;
            cd.cd_yb  <= '0;
            cd.cd_vxb <= '0;
            cd.cd_vyb <= '0;
            cd.cd_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i_idx     <= '0;
                        j_idx     <= IDX_W'(1);
                        hit_mask  <= '0;
                        hit_count <= '0;
                    end
                end
                ISSUE: begin
                    cd.cd_xa  <= snap_x[i_idx];
                    cd.cd_ya  <= snap_y[i_idx];
                    cd.cd_vxa <= snap_vx[i_idx];
                    cd.cd_vya <= snap_vy[i_idx];
                    cd.cd_xb  <= snap_x[j_idx];
                    cd.cd_yb  <= snap_y[j_idx];
                    cd.cd_vxb <= snap_vx[j_idx];
                    cd.cd_vyb <= snap_vy[j_idx];
                    cd.cd_r   <= radius;
                end
                WAIT: begin
                    if (cd.cd_out_rdy && cd.cd_hit) begin
                        hit_mask <= hit_mask | pair_bits;
                        if (hit_count != 8'hFF) begin
                            hit_count <= hit_count + 8'd1;
                        end
                    end
                end
                NEXT: begin
                    if (!last_pair) begin
                        if (j_idx == IDX_W'(NUM_BOTS - 1)) begin
                            i_idx <= i_idx + IDX_W'(1);
                            j_idx <= i_idx + IDX_W'(2);
                        end else begin
                            j_idx <= j_idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
